// File: rtl/cpu_load_ctrl_if.sv
// Host-side byte stream, CPU load port and run-status bundle for cpu_load_ctrl.
// The slave modport is the controller; the master modport is the host/CPU side.
interface cpu_load_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 2,
  parameter int CYC_W  = 24
);
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              rx_ready;
  logic              cpu_done;
  logic              load_en;
  logic [SEL_W-1:0]  load_sel;
  logic [DATA_W-1:0] load_data;
  logic              cpu_rst_n;
  logic              busy;
  logic [CYC_W-1:0]  run_cycles;
  logic              err;

  modport master (
    output rx_valid, rx_byte, cpu_done,
    input  rx_ready, load_en, load_sel, load_data, cpu_rst_n, busy, run_cycles, err
  );

  modport slave (
    input  rx_valid, rx_byte, cpu_done,
    output rx_ready, load_en, load_sel, load_data, cpu_rst_n, busy, run_cycles, err
  );
endinterface

// File: rtl/cpu_load_ctrl.sv
// Byte-stream program loader and run supervisor for a small CPU.
// Optional inter-byte timeout is built in when LOAD_TIMEOUT_EN is defined.
module cpu_load_ctrl #(
  parameter int DATA_W  = 16,
  parameter int SEL_W   = 2,
  parameter int CYC_W   = 24,
  parameter int TIMEOUT = 1000
) (
  input  logic           clk,
  input  logic           reset,
  cpu_load_ctrl_if.slave bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_COUNT  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  localparam int                BYTES     = DATA_W / 8;
  localparam int                BIDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);
  localparam logic [CYC_W-1:0]  CYC_MAX   = '1;

  if ((DATA_W % 8 != 0) || (DATA_W < 8) || (DATA_W > 64) ||
      (SEL_W < 1) || (SEL_W > 6) || (TIMEOUT < 1)) begin : g_bad_cfg
    $error("cpu_load_ctrl: illegal parameter set");
  end

  logic [2:0]        state_r,      state_nxt_s;
  logic [SEL_W-1:0]  sel_r,        sel_nxt_s;
  logic [8:0]        words_left_r, words_left_nxt_s;
  logic [BIDX_W-1:0] byte_idx_r,   byte_idx_nxt_s;
  logic [DATA_W-1:0] shift_r,      shift_nxt_s;
  logic [CYC_W-1:0]  cyc_cnt_r,    cyc_cnt_nxt_s;
  logic              load_en_r,    load_en_nxt_s;
  logic [SEL_W-1:0]  load_sel_r,   load_sel_nxt_s;
  logic [DATA_W-1:0] load_data_r,  load_data_nxt_s;
  logic [CYC_W-1:0]  run_cycles_r, run_cycles_nxt_s;
  logic              err_r,        err_nxt_s;
  logic              rx_ready_r,   rx_ready_nxt_s;
  logic              busy_r;
  logic              cpu_rst_n_r;
  logic              accept_s;
  logic [DATA_W-1:0] assembled_s;

`ifdef LOAD_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_nxt_s;
`endif

  assign accept_s    = bus.rx_valid && rx_ready_r;
  assign assembled_s = (shift_r << 8) | DATA_W'(bus.rx_byte);

  // Next-state and next-output computation for the loader FSM.
  always_comb begin
    state_nxt_s      = state_r;
    sel_nxt_s        = sel_r;
    words_left_nxt_s = words_left_r;
    byte_idx_nxt_s   = byte_idx_r;
    shift_nxt_s      = shift_r;
    cyc_cnt_nxt_s    = cyc_cnt_r;
    load_en_nxt_s    = 1'b0;
    load_sel_nxt_s   = load_sel_r;
    load_data_nxt_s  = load_data_r;
    run_cycles_nxt_s = run_cycles_r;
    err_nxt_s        = err_r;
`ifdef LOAD_TIMEOUT_EN
    tmo_cnt_nxt_s    = '0;
`endif

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (bus.rx_byte[6]) begin
            err_nxt_s = 1'b1;
          end else if (bus.rx_byte[7]) begin
            err_nxt_s     = 1'b0;
            state_nxt_s   = ST_RUN;
            // The entry cycle itself is the first counted cycle.
            cyc_cnt_nxt_s = CYC_W'(1);
          end else begin
            err_nxt_s   = 1'b0;
            sel_nxt_s   = bus.rx_byte[SEL_W-1:0];
            state_nxt_s = ST_COUNT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (accept_s) begin
          words_left_nxt_s = (bus.rx_byte == 8'd0) ? 9'd256 : {1'b0, bus.rx_byte};
          byte_idx_nxt_s   = '0;
          state_nxt_s      = ST_DATA;
        end else begin
          state_nxt_s = ST_COUNT;
        end
      end
      ST_DATA: begin
        if (load_en_r) begin
          // Strobe cycle: no byte is taken; leave once the last word is out.
          if (words_left_r == 9'd0) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else if (accept_s) begin
          shift_nxt_s = assembled_s;
          if (byte_idx_r == LAST_BYTE) begin
            load_en_nxt_s    = 1'b1;
            load_data_nxt_s  = assembled_s;
            load_sel_nxt_s   = sel_r;
            words_left_nxt_s = words_left_r - 9'd1;
            byte_idx_nxt_s   = '0;
          end else begin
            byte_idx_nxt_s = byte_idx_r + BIDX_W'(1);
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_RUN: begin
        if (bus.cpu_done) begin
          run_cycles_nxt_s = cyc_cnt_r;
          state_nxt_s      = ST_FINISH;
        end else if (cyc_cnt_r == CYC_MAX) begin
          err_nxt_s = 1'b1;
        end else begin
          cyc_cnt_nxt_s = cyc_cnt_r + CYC_W'(1);
        end
      end
      ST_FINISH: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

`ifdef LOAD_TIMEOUT_EN
    if (((state_r == ST_COUNT) || (state_r == ST_DATA)) && !accept_s) begin
      if (tmo_cnt_r == TMO_LAST) begin
        state_nxt_s    = ST_IDLE;
        err_nxt_s      = 1'b1;
        load_en_nxt_s  = 1'b0;
        byte_idx_nxt_s = '0;
        tmo_cnt_nxt_s  = '0;
      end else begin
        tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
      end
    end else begin
      tmo_cnt_nxt_s = '0;
    end
`endif

    // Ready is withheld during the strobe cycle so the stream pauses there.
    rx_ready_nxt_s = ((state_nxt_s == ST_IDLE) || (state_nxt_s == ST_COUNT) ||
                      (state_nxt_s == ST_DATA)) && !load_en_nxt_s;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      sel_r        <= '0;
      words_left_r <= 9'd0;
      byte_idx_r   <= '0;
      shift_r      <= '0;
      cyc_cnt_r    <= '0;
      load_en_r    <= 1'b0;
      load_sel_r   <= '0;
      load_data_r  <= '0;
      run_cycles_r <= '0;
      err_r        <= 1'b0;
      rx_ready_r   <= 1'b0;
      busy_r       <= 1'b0;
      cpu_rst_n_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      sel_r        <= sel_nxt_s;
      words_left_r <= words_left_nxt_s;
      byte_idx_r   <= byte_idx_nxt_s;
      shift_r      <= shift_nxt_s;
      cyc_cnt_r    <= cyc_cnt_nxt_s;
      load_en_r    <= load_en_nxt_s;
      load_sel_r   <= load_sel_nxt_s;
      load_data_r  <= load_data_nxt_s;
      run_cycles_r <= run_cycles_nxt_s;
      err_r        <= err_nxt_s;
      rx_ready_r   <= rx_ready_nxt_s;
      busy_r       <= (state_nxt_s != ST_IDLE);
      cpu_rst_n_r  <= (state_nxt_s == ST_RUN);
    end
  end

`ifdef LOAD_TIMEOUT_EN
  // Inter-byte silence counter for COUNT/DATA.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_nxt_s;
    end
  end
`endif

  assign bus.rx_ready   = rx_ready_r;
  assign bus.load_en    = load_en_r;
  assign bus.load_sel   = load_sel_r;
  assign bus.load_data  = load_data_r;
  assign bus.cpu_rst_n  = cpu_rst_n_r;
  assign bus.busy       = busy_r;
  assign bus.run_cycles = run_cycles_r;
  assign bus.err        = err_r;

endmodule

// File: tb/tb_cpu_load_ctrl.sv
// Self-checking bench for cpu_load_ctrl: random frames and runs against a
// frame-level reference model (expected strobe queue, run-length arithmetic).
module tb_cpu_load_ctrl;
  localparam int DATA_W  = 16;
  localparam int SEL_W   = 2;
  localparam int CYC_W   = 5;
  localparam int TIMEOUT = 1000;
  localparam int BYTES   = DATA_W / 8;
  localparam int RUN_MAX = (1 << CYC_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   ready_in_strobe = 0;
  logic [SEL_W+DATA_W-1:0] got_q[$];
  logic [SEL_W+DATA_W-1:0] exp_q[$];

  cpu_load_ctrl_if #(.DATA_W(DATA_W), .SEL_W(SEL_W), .CYC_W(CYC_W)) bus ();

  cpu_load_ctrl #(.DATA_W(DATA_W), .SEL_W(SEL_W), .CYC_W(CYC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Record every strobe cycle seen on the load port.
  always @(negedge clk) begin
    if (bus.load_en === 1'b1) begin
      got_q.push_back({bus.load_sel, bus.load_data});
      if (bus.rx_ready !== 1'b0) ready_in_strobe++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int  budget;
    bit  done;
    budget = 50;
    done   = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    while (!done && budget > 0) begin
      if (bus.rx_ready === 1'b1) done = 1'b1;
      @(negedge clk);
      budget--;
    end
    bus.rx_valid = 1'b0;
    check_eq("byte_accepted", 64'(done), 64'd1);
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    for (int k = BYTES - 1; k >= 0; k--) send_byte(w[8*k +: 8]);
  endtask

  task automatic end_frame(input string tag);
    int n;
    repeat (2) @(negedge clk);
    check_eq({tag, "_busy_idle"}, 64'(bus.busy), 64'd0);
    check_eq({tag, "_strobe_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq({tag, "_strobe"}, 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  // Header 0x80, cpu_done presented d cycles after RUN entry.
  task automatic run_test(input int d, input string tag);
    int   hi;
    logic b_fin, r_fin, b_after;
    int   exp_cycles;
    send_byte(8'h80);
    hi = 0;
    b_fin = 1'b0; r_fin = 1'b1; b_after = 1'b1;
    for (int i = 0; i < d + 4; i++) begin
      if (bus.cpu_rst_n === 1'b1) hi++;
      if (i == d + 1) begin
        b_fin = bus.busy;
        r_fin = bus.cpu_rst_n;
      end
      if (i == d + 2) b_after = bus.busy;
      if (i == d) bus.cpu_done = 1'b1;
      @(negedge clk);
      bus.cpu_done = 1'b0;
    end
    exp_cycles = (d + 1 > RUN_MAX) ? RUN_MAX : d + 1;
    check_eq({tag, "_rst_high"}, 64'(hi), 64'(d + 1));
    check_eq({tag, "_run_cycles"}, 64'(bus.run_cycles), 64'(exp_cycles));
    check_eq({tag, "_err"}, 64'(bus.err), 64'((d + 1 > RUN_MAX) ? 1 : 0));
    check_eq({tag, "_finish_busy"}, 64'(b_fin), 64'd1);
    check_eq({tag, "_finish_rst"}, 64'(r_fin), 64'd0);
    check_eq({tag, "_after_busy"}, 64'(b_after), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    bus.rx_valid = 1'b0;
    bus.cpu_done = 1'b0;
    #1;
    check_eq({tag, "_load_en"}, 64'(bus.load_en), 64'd0);
    check_eq({tag, "_load_sel"}, 64'(bus.load_sel), 64'd0);
    check_eq({tag, "_load_data"}, 64'(bus.load_data), 64'd0);
    check_eq({tag, "_cpu_rst_n"}, 64'(bus.cpu_rst_n), 64'd0);
    check_eq({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check_eq({tag, "_run_cycles"}, 64'(bus.run_cycles), 64'd0);
    check_eq({tag, "_err"}, 64'(bus.err), 64'd0);
    check_eq({tag, "_rx_ready"}, 64'(bus.rx_ready), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq({tag, "_ready_after"}, 64'(bus.rx_ready), 64'd1);
    check_eq({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [7:0]        hdr;
    logic [DATA_W-1:0] w;
    int                n;

    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    bus.cpu_done = 1'b0;
    do_reset("por");

    // Two-word frame with latency check on the first strobe.
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    check_eq("lat_load_en", 64'(bus.load_en), 64'd1);
    check_eq("lat_load_data", 64'(bus.load_data), 64'h1234);
    check_eq("lat_load_sel", 64'(bus.load_sel), 64'd1);
    check_eq("lat_rx_ready", 64'(bus.rx_ready), 64'd0);
    exp_q.push_back({2'd1, 16'h1234});
    exp_q.push_back({2'd1, 16'hABCD});
    send_byte(8'hAB);
    send_byte(8'hCD);
    end_frame("two_words");

    run_test(10, "run10");
    run_test(0, "run0");
    run_test(RUN_MAX - 1, "run_edge");
    run_test(RUN_MAX, "run_sat");
    for (int r = 0; r < 3; r++) run_test($urandom_range(0, 40), "run_rand");

    // Unused header bit: error flag, byte dropped, cleared only by reset or a good header.
    send_byte(8'h40);
    check_eq("hdr40_err", 64'(bus.err), 64'd1);
    check_eq("hdr40_busy", 64'(bus.busy), 64'd0);
    do_reset("rst_err");
    send_byte(8'hC0);
    check_eq("hdrC0_err", 64'(bus.err), 64'd1);
    check_eq("hdrC0_busy", 64'(bus.busy), 64'd0);
    send_byte(8'h03);
    check_eq("hdr_clears_err", 64'(bus.err), 64'd0);
    send_byte(8'h01);
    w = 16'h5AA5;
    exp_q.push_back({2'd3, w});
    send_word(w);
    end_frame("after_err");

    // Count byte 0 means 256 words, streamed back-to-back.
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      w = DATA_W'($urandom);
      exp_q.push_back({2'd2, w});
      send_word(w);
    end
    end_frame("count256");

    for (int f = 0; f < 6; f++) begin
      hdr = {2'b00, 6'($urandom)};
      n   = $urandom_range(1, 5);
      send_byte(hdr);
      send_byte(8'(n));
      for (int i = 0; i < n; i++) begin
        w = DATA_W'($urandom);
        exp_q.push_back({hdr[SEL_W-1:0], w});
        send_word(w);
        if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      end_frame("rand_frame");
    end

    // Reset after one byte of a word: nothing strobed, everything back to reset values.
    run_test(5, "run_pre_rst");
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h5A);
    do_reset("rst_mid");
    check_eq("rst_mid_no_strobe", 64'(got_q.size()), 64'd0);
    got_q.delete();

`ifdef LOAD_TIMEOUT_EN
    send_byte(8'h01);
    repeat (TIMEOUT - 1) @(negedge clk);
    check_eq("tmo_before_busy", 64'(bus.busy), 64'd1);
    check_eq("tmo_before_err", 64'(bus.err), 64'd0);
    @(negedge clk);
    check_eq("tmo_err", 64'(bus.err), 64'd1);
    check_eq("tmo_idle", 64'(bus.busy), 64'd0);
    send_byte(8'h00);
    check_eq("tmo_err_cleared", 64'(bus.err), 64'd0);
    send_byte(8'h01);
    w = 16'hBEEF;
    exp_q.push_back({2'd0, w});
    send_word(w);
    end_frame("tmo_recover");
`endif

    check_eq("ready_low_in_strobe", 64'(ready_in_strobe), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cpu_load_ctrl.md
CPU_LOAD_CTRL -- requirements
Module: cpu_load_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, width of the loaded word; SHALL be a multiple of 8, range 8..64.
REQ-002 Parameter SEL_W, default 2, width of the load-target select; SHALL be 1..6.
REQ-003 Parameter CYC_W, default 24, width of the run-cycle counter.
REQ-004 Parameter TIMEOUT, default 1000, inter-byte timeout in clock cycles, used only when LOAD_TIMEOUT_EN is defined.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 rx_valid  input  1  received byte available.
REQ-008 rx_byte  input  8  received byte.
REQ-009 rx_ready  output  1  byte accepted when rx_valid and rx_ready are both high.
REQ-010 cpu_done  input  1  CPU program-finished flag.
REQ-011 load_en  output  1  one-cycle write strobe to the CPU load port.
REQ-012 load_sel  output  SEL_W  load target, valid while load_en is high.
REQ-013 load_data  output  DATA_W  assembled word, valid while load_en is high.
REQ-014 cpu_rst_n  output  1  active-low CPU hold; low except in RUN.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 run_cycles  output  CYC_W  cycles counted in the last RUN.
REQ-017 err  output  1  sticky error flag.

Function
REQ-018 States: IDLE, COUNT, DATA, RUN, FINISH.
REQ-019 IDLE: accepting a byte SHALL decode a header: bit7=1 -> RUN; bit7=0 -> latch sel=byte[SEL_W-1:0] and go to COUNT.
REQ-020 COUNT: the accepted byte SHALL be the word count N; N=0 means 256. Next state is DATA.
REQ-021 DATA: bytes SHALL be assembled MSB-first; after DATA_W/8 bytes, load_en SHALL pulse high for exactly one cycle, with load_data and load_sel stable during the pulse.
REQ-022 The load_en pulse SHALL occur on the cycle after the final byte of a word is accepted (latency 1).
REQ-023 After the Nth word strobe, the FSM SHALL return to IDLE.
REQ-024 rx_ready SHALL be high in IDLE, COUNT and DATA, and low in RUN and FINISH, and also low during the load_en cycle.
REQ-025 RUN: cpu_rst_n=1; the internal counter SHALL clear on entry and increment every cycle; it SHALL saturate at all-ones and set err.
REQ-026 RUN with cpu_done=1: latch the count into run_cycles, then go to FINISH; cpu_done sampled on the entry cycle counts as 1 cycle.
REQ-027 FINISH: cpu_rst_n=0 and busy=1 for one cycle, then IDLE.
REQ-028 An unused header bit6=1 in IDLE SHALL set err, and the byte SHALL be discarded.
REQ-029 err SHALL clear only on reset or when the next valid header is accepted.

Reset
REQ-030 When reset is asserted low, the block SHALL immediately enter IDLE with load_en=0, load_sel=0, load_data=0, cpu_rst_n=0, busy=0, run_cycles=0, err=0 and rx_ready=0; rx_ready SHALL go high on the first clock after release.
REQ-031 Reset during DATA or RUN SHALL abandon the frame; no partial word SHALL be strobed.

Configuration
REQ-032 Macro LOAD_TIMEOUT_EN defined: in COUNT or DATA, TIMEOUT cycles without an accepted byte SHALL set err and return the FSM to IDLE, discarding any partial word.
REQ-033 Macro LOAD_TIMEOUT_EN undefined: no timeout counter exists, and COUNT/DATA wait indefinitely.

Verification
REQ-034 DATA_W=16: bytes 0x01,0x02,0x12,0x34,0xAB,0xCD -> two strobes, sel=1, data 0x1234 then 0xABCD, then IDLE.
REQ-035 Header 0x80, cpu_done raised 10 cycles after RUN entry -> cpu_rst_n high for 11 cycles, run_cycles=11, busy low 1 cycle after FINISH.
REQ-036 Count byte 0x00 -> exactly 256 strobes before return to IDLE.
REQ-037 Reset pulsed after 1 byte of a word -> no load_en, all outputs at reset values.
REQ-038 LOAD_TIMEOUT_EN, TIMEOUT=1000: stall after header -> err=1 and IDLE at cycle 1000; next header 0x00 clears err.
REQ-039 Header 0x40 -> err=1, no state change; rx_valid held constantly with back-to-back bytes -> no byte lost across load_en cycles.
